// File: rtl/instruction_dump_tx.sv
// Instruction store read-back: walks memory 0..WORDS-1 and sends each 16-bit word over an
// 8N1 UART, high byte first.
module instruction_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned WORDS        = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [15:0]           read_data,
    output logic                  UART_RXD_OUT,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(WORDS - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop} state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic              byte_sel;  // 1 while the high byte of hold is on the line
    logic [15:0]       hold;
    logic [7:0]        cur_byte;
    logic              baud_tick;

    assign cur_byte  = byte_sel ? hold[15:8] : hold[7:0];
    assign baud_tick = (baud_cnt == BAUD_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= StIdle;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            byte_sel     <= 1'b0;
            hold         <= '0;
            read_addr    <= '0;
            UART_RXD_OUT <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    UART_RXD_OUT <= 1'b1;
                    if (start) begin
                        state     <= StLoad;
                        busy      <= 1'b1;
                        read_addr <= '0;
                    end
                end
                StLoad: begin
                    hold         <= read_data;
                    byte_sel     <= 1'b1;
                    baud_cnt     <= '0;
                    UART_RXD_OUT <= 1'b0;
                    state        <= StStart;
                end
                StStart: begin
                    if (baud_tick) begin
                        baud_cnt     <= '0;
                        bit_idx      <= '0;
                        UART_RXD_OUT <= cur_byte[0];
                        state        <= StData;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                StData: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            UART_RXD_OUT <= 1'b1;
                            state        <= StStop;
                        end else begin
                            bit_idx      <= bit_idx + 3'd1;
                            UART_RXD_OUT <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                StStop: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (byte_sel) begin
                            // Low byte follows immediately, no idle cycle.
                            byte_sel     <= 1'b0;
                            UART_RXD_OUT <= 1'b0;
                            state        <= StStart;
                        end else if (read_addr < ADDR_LAST) begin
                            read_addr <= read_addr + ADDR_WIDTH'(1);
                            state     <= StLoad;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_dump_tx.sv
// Scoreboard bench: two DUT configurations, a UART frame decoder per line, expected bytes and
// done times queued when each dump is launched.
module tb_instruction_dump_tx;

    localparam int CPB_A = 4, AW_A = 5, WORDS_A = 32;
    localparam int CPB_B = 2, AW_B = 1, WORDS_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            rst_a, start_a, line_a, busy_a, done_a;
    logic [AW_A-1:0] addr_a;
    logic [15:0]     mem_a [WORDS_A];
    logic [15:0]     rd_a;
    assign rd_a = mem_a[addr_a];

    logic            rst_b, start_b, line_b, busy_b, done_b;
    logic [AW_B-1:0] addr_b;
    logic [15:0]     mem_b [2];
    logic [15:0]     rd_b;
    assign rd_b = mem_b[addr_b];

    instruction_dump_tx #(.CLKS_PER_BIT(CPB_A), .ADDR_WIDTH(AW_A), .WORDS(WORDS_A)) dut_a (
        .CLK(clk), .RST(rst_a), .start(start_a), .read_addr(addr_a), .read_data(rd_a),
        .UART_RXD_OUT(line_a), .busy(busy_a), .done(done_a)
    );

    instruction_dump_tx #(.CLKS_PER_BIT(CPB_B), .ADDR_WIDTH(AW_B), .WORDS(WORDS_B)) dut_b (
        .CLK(clk), .RST(rst_b), .start(start_b), .read_addr(addr_b), .read_data(rd_b),
        .UART_RXD_OUT(line_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic [7:0] b;
        int         gap;  // idle-high cycles before this frame; -1 = don't care
    } exp_t;

    exp_t qa[$], qb[$];
    int   da[$], db[$];
    int   checks = 0, failures = 0;

    int         in_frame [2] = '{0, 0};
    int         s        [2] = '{0, 0};
    int         gap      [2] = '{0, 0};
    int         fgap     [2] = '{0, 0};
    int         nbytes   [2] = '{0, 0};
    int         ndone    [2] = '{0, 0};
    logic [7:0] shreg    [2];
    logic       cur      [2];

    task automatic check(string name, int i, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] at cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
        end
    endtask

    // Expected stream for a dump whose start is driven while cyc == c.
    task automatic push_dump(int i, int c);
        int         words, cpb;
        logic [15:0] w;
        words = (i == 0) ? WORDS_A : WORDS_B;
        cpb   = (i == 0) ? CPB_A : CPB_B;
        for (int k = 0; k < words; k++) begin
            w = (i == 0) ? mem_a[k] : mem_b[k];
            if (i == 0) begin
                qa.push_back('{w[15:8], (k == 0) ? -1 : 1});
                qa.push_back('{w[7:0], 0});
            end else begin
                qb.push_back('{w[15:8], (k == 0) ? -1 : 1});
                qb.push_back('{w[7:0], 0});
            end
        end
        if (i == 0) da.push_back(c + 1 + words * (20 * cpb + 1));
        else        db.push_back(c + 1 + words * (20 * cpb + 1));
    endtask

    task automatic mon_step(int i, logic r, logic line, logic bsy, logic dn, int cpb);
        int   bitn, pos;
        exp_t e;
        bit   have;
        if (r) begin
            in_frame[i] = 0;
            gap[i]      = 0;
            return;
        end
        if (dn) begin
            ndone[i]++;
            have = 0;
            if (i == 0 && da.size() > 0) begin
                check("done_cycle", i, cyc, da.pop_front());
                have = 1;
            end else if (i == 1 && db.size() > 0) begin
                check("done_cycle", i, cyc, db.pop_front());
                have = 1;
            end
            if (!have) check("done_unexpected", i, 1, 0);
            check("busy_at_done", i, bsy, 0);
        end
        if (in_frame[i] == 0) begin
            if (line == 1'b0) begin
                in_frame[i] = 1;
                s[i]        = 0;
                fgap[i]     = gap[i];
            end else begin
                gap[i]++;
            end
        end
        if (in_frame[i] != 0) begin
            bitn = s[i] / cpb;
            pos  = s[i] % cpb;
            if (bitn == 0) begin
                check("start_bit", i, line, 0);
            end else if (bitn <= 8) begin
                if (pos == 0) begin
                    shreg[i][bitn-1] = line;
                    cur[i]           = line;
                end else begin
                    check("bit_stable", i, line, cur[i]);
                end
            end else begin
                check("stop_bit", i, line, 1);
            end
            if (s[i] == 10 * cpb - 1) begin
                have = 0;
                if (i == 0 && qa.size() > 0) begin
                    e = qa.pop_front();
                    have = 1;
                end else if (i == 1 && qb.size() > 0) begin
                    e = qb.pop_front();
                    have = 1;
                end
                if (!have) begin
                    check("byte_unexpected", i, shreg[i], -1);
                end else begin
                    check("byte", i, shreg[i], e.b);
                    if (e.gap >= 0) check("gap", i, fgap[i], e.gap);
                end
                nbytes[i]++;
                in_frame[i] = 0;
                gap[i]      = 0;
            end
            s[i]++;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, rst_a, line_a, busy_a, done_a, CPB_A);
        mon_step(1, rst_b, line_b, busy_b, done_b, CPB_B);
    end

    // Called at a negedge; returns one negedge later with the dump accepted.
    task automatic issue_dump(int i);
        push_dump(i, cyc);
        if (i == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        if (i == 0) begin
            check("busy_after_start", i, busy_a, 1);
            check("addr_after_start", i, addr_a, 0);
        end else begin
            check("busy_after_start", i, busy_b, 1);
            check("addr_after_start", i, addr_b, 0);
        end
    endtask

    task automatic wait_bytes(int n, int limit);
        int t = 0;
        while (nbytes[0] < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (nbytes[0] < n) check("byte_timeout", 0, nbytes[0], n);
    endtask

    task automatic wait_done(int i, int limit);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (((i == 0) ? done_a : done_b) !== 1'b1 && t < limit);
        if (((i == 0) ? done_a : done_b) !== 1'b1) check("done_timeout", i, 0, 1);
    endtask

    task automatic randomize_a();
        for (int k = 0; k < WORDS_A; k++) mem_a[k] = 16'($urandom);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    initial begin
        int base, t;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        randomize_a();
        mem_b[0] = 16'hF804;
        mem_b[1] = 16'h0000;
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("idle_line", 0, line_a, 1);
            check("idle_busy", 0, busy_a, 0);
            check("idle_done", 0, done_a, 0);
            check("idle_addr", 0, addr_a, 0);
            check("idle_line", 1, line_b, 1);
        end

        // Single-word configuration.
        issue_dump(1);
        wait_done(1, 200);
        @(negedge clk);

        // Dump 1 with start re-pulsed mid-stream.
        mem_a[0] = 16'h1050;
        mem_a[1] = 16'h114E;
        base = nbytes[0];
        issue_dump(0);
        wait_bytes(base + 3, 400);
        pulse_start_a();
        wait_bytes(base + 40, 3000);
        pulse_start_a();
        wait_done(0, 3000);

        // Dump 2 started in the same cycle done is seen.
        randomize_a();
        issue_dump(0);
        wait_done(0, 3000);
        @(negedge clk);

        // Dump 3 aborted by reset inside data bit 4 of byte index 5.
        randomize_a();
        mem_a[0] = 16'h1050;
        base = nbytes[0];
        issue_dump(0);
        wait_bytes(base + 5, 800);
        t = 0;
        while (in_frame[0] == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (5 * CPB_A + 1) @(negedge clk);
        rst_a = 1'b1;
        qa.delete();
        da.delete();
        @(negedge clk);
        check("rst_line", 0, line_a, 1);
        check("rst_busy", 0, busy_a, 0);
        check("rst_done", 0, done_a, 0);
        check("rst_addr", 0, addr_a, 0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (3) @(negedge clk);

        // Dump 4 restarts from address 0; word 0 is rewritten after it has been latched.
        randomize_a();
        mem_a[0] = 16'h1050;
        issue_dump(0);
        @(negedge clk);
        mem_a[0] = ~mem_a[0];
        wait_done(0, 3000);
        repeat (10) @(negedge clk);

        check("pending_bytes", 0, qa.size(), 0);
        check("pending_done", 0, da.size(), 0);
        check("pending_bytes", 1, qb.size(), 0);
        check("pending_done", 1, db.size(), 0);
        check("done_count", 0, ndone[0], 3);
        check("done_count", 1, ndone[1], 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
